// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_pkg: shared state encoding and control-field layout for pipe_stage_skid
package pipe_stage_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;
  localparam int WB_W = 10;
  localparam int MEM_W = 3;
  localparam int MEMREAD = 2;
  localparam int MEMWRITE = 1;
  localparam int MEMWRITE64 = 0;
  localparam logic [WB_W+MEM_W-1:0] NOP_CTRL = '0;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready channel carrying one {data, ctrl} entry
interface pipe_stage_skid_if #(
  parameter int DATA_W = 229,
  parameter int CTRL_W = 13
);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  modport master(output valid, data, ctrl, input ready);
  modport slave(input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// pipe_stage_entry_reg: {data, ctrl} holding register with load enable and ctrl-only clear
module pipe_stage_entry_reg #(
  parameter int DATA_W = 229,
  parameter int CTRL_W = 13
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);
  // clear kills only ctrl so a dead entry reads as NOP; data is left stale
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_data <= '0;
      q_ctrl <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
    end else if (ld) begin
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: flow-controlled pipeline stage with 2-entry skid buffer; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipe_stage_skid
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 229,
  parameter int CTRL_W = 13
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic Clk,
  input  logic Rst,
  input  logic flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);
  state_t state;
  logic acc, pop, out_valid;
  logic main_ld, main_clr, skid_ld;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  assign out_valid = (state != EMPTY);
  assign up.ready = (state != SKID);
  assign acc = up.valid & up.ready;
  assign pop = out_valid & dn.ready;
  // main refills from upstream, or from skid when draining the second entry
  always_comb begin
    main_ld = ((state == EMPTY) & acc) | ((state == FULL) & acc & pop) | ((state == SKID) & pop);
    main_clr = flush | ((state == FULL) & pop & ~acc);
    skid_ld = (state == FULL) & acc & ~pop;
    main_d_data = (state == SKID) ? skid_data : up.data;
    main_d_ctrl = (state == SKID) ? skid_ctrl : up.ctrl;
  end
  pipe_stage_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .Clk(Clk), .Rst(Rst), .ld(main_ld), .clr(main_clr),
    .d_data(main_d_data), .d_ctrl(main_d_ctrl),
    .q_data(main_data), .q_ctrl(main_ctrl)
  );
  pipe_stage_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .Clk(Clk), .Rst(Rst), .ld(skid_ld), .clr(flush),
    .d_data(up.data), .d_ctrl(up.ctrl),
    .q_data(skid_data), .q_ctrl(skid_ctrl)
  );
  // occupancy FSM; reset and flush both drop to EMPTY
  always_ff @(posedge Clk) begin
    if (Rst || flush)
      state <= EMPTY;
    else
      state <= (state == EMPTY) ? (acc ? FULL : EMPTY) :
               (state == FULL)  ? ((acc & ~pop) ? SKID : (~acc & pop) ? EMPTY : FULL) :
               (pop ? FULL : SKID);
  end
  assign dn.valid = out_valid;
  assign dn.data = main_data;
  assign dn.ctrl = out_valid ? main_ctrl : CTRL_W'(NOP_CTRL);
`ifdef PIPE_STAGE_PERF_EN
  // saturating counters: stalls are held heads, bubbles are empty or flushed cycles
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt <= (out_valid & ~dn.ready & ~&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
      bubble_cnt <= ((~out_valid | flush) & ~&bubble_cnt) ? bubble_cnt + 1'b1 : bubble_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int DW = 229;
  localparam int CW = 13;
  localparam int NW = 4;
  logic Clk = 0;
  logic Rst, flush;
  int n_cmp = 0;
  int n_err = 0;
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn ();
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt, bubble_cnt;
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush), .up(up), .dn(dn),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );
`else
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush), .up(up), .dn(dn)
  );
`endif
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1; flush = 0; up.valid = 0; up.data = '0; up.ctrl = '0; dn.ready = 0;
    step(); step();
    n_cmp++; if (up.ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", up.ready); end
    n_cmp++; if (dn.valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", dn.valid); end
    n_cmp++; if (dn.data !== '0) begin n_err++; $display("FAIL reset_out_data got %h exp 0", dn.data); end
    n_cmp++; if (dn.ctrl !== '0) begin n_err++; $display("FAIL reset_out_ctrl got %h exp 0", dn.ctrl); end
    Rst = 0;
  endtask

  task automatic test_stream();
    up.valid = 1; up.ctrl = 13'h1A5; dn.ready = 1;
    for (int i = 1; i <= 8; i++) begin
      up.data = DW'(i);
      step();
      n_cmp++; if (dn.valid !== 1'b1 || dn.data !== DW'(i) || dn.ctrl !== 13'h1A5 || up.ready !== 1'b1) begin
        n_err++; $display("FAIL stream_%0d got v=%b d=%h c=%h r=%b exp v=1 d=%0d c=1a5 r=1", i, dn.valid, dn.data, dn.ctrl, up.ready, i);
      end
    end
    up.valid = 0; up.data = 'x; up.ctrl = 'x;
    step();
    n_cmp++; if (dn.valid !== 1'b0 || dn.ctrl !== '0) begin n_err++; $display("FAIL stream_drain got v=%b c=%h exp v=0 c=0", dn.valid, dn.ctrl); end
    step();
    n_cmp++; if (dn.ctrl !== '0) begin n_err++; $display("FAIL x_idle_ctrl got %h exp 0", dn.ctrl); end
  endtask

  task automatic test_backpressure();
    up.valid = 1; up.ctrl = 13'h003; up.data = DW'(8'h10); dn.ready = 1;
    step();
    up.data = DW'(8'h11); dn.ready = 0;
    step();
    n_cmp++; if (dn.data !== DW'(8'h10) || up.ready !== 1'b0) begin n_err++; $display("FAIL bp_skid got d=%h r=%b exp d=10 r=0", dn.data, up.ready); end
    up.data = DW'(8'h12);
    step();
    n_cmp++; if (dn.valid !== 1'b1 || dn.data !== DW'(8'h10) || up.ready !== 1'b0) begin n_err++; $display("FAIL bp_hold got v=%b d=%h r=%b exp v=1 d=10 r=0", dn.valid, dn.data, up.ready); end
    dn.ready = 1;
    step();
    n_cmp++; if (dn.valid !== 1'b1 || dn.data !== DW'(8'h11) || up.ready !== 1'b1) begin n_err++; $display("FAIL bp_rel1 got v=%b d=%h r=%b exp v=1 d=11 r=1", dn.valid, dn.data, up.ready); end
    step();
    n_cmp++; if (dn.valid !== 1'b1 || dn.data !== DW'(8'h12)) begin n_err++; $display("FAIL bp_rel2 got v=%b d=%h exp v=1 d=12", dn.valid, dn.data); end
    up.valid = 0;
    step();
    n_cmp++; if (dn.valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b exp 0", dn.valid); end
  endtask

  task automatic test_flush();
    up.valid = 1; up.ctrl = 13'h1FF; up.data = DW'(8'h20); dn.ready = 0;
    step();
    up.data = DW'(8'h21);
    step();
    n_cmp++; if (up.ready !== 1'b0) begin n_err++; $display("FAIL flush_fill got r=%b exp 0", up.ready); end
    flush = 1; up.data = DW'(8'h99);
    step();
    flush = 0; up.valid = 0;
    n_cmp++; if (dn.valid !== 1'b0 || dn.ctrl !== '0 || up.ready !== 1'b1) begin n_err++; $display("FAIL flush_kill got v=%b c=%h r=%b exp v=0 c=0 r=1", dn.valid, dn.ctrl, up.ready); end
    dn.ready = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (dn.valid !== 1'b0) begin n_err++; $display("FAIL flush_no99 got v=%b d=%h exp v=0", dn.valid, dn.data); end
    end
  endtask

  task automatic test_back_to_back();
    up.valid = 1; up.ctrl = 13'h011; up.data = DW'(5); dn.ready = 1;
    step();
    n_cmp++; if (dn.data !== DW'(5)) begin n_err++; $display("FAIL b2b_first got %h exp 5", dn.data); end
    up.data = DW'(6);
    step();
    n_cmp++; if (dn.valid !== 1'b1 || dn.data !== DW'(6) || up.ready !== 1'b1) begin n_err++; $display("FAIL b2b_swap got v=%b d=%h r=%b exp v=1 d=6 r=1", dn.valid, dn.data, up.ready); end
    up.valid = 0;
    step();
    n_cmp++; if (dn.valid !== 1'b0) begin n_err++; $display("FAIL b2b_once got v=%b d=%h exp v=0", dn.valid, dn.data); end
  endtask

  task automatic test_reset_mid();
    up.valid = 1; up.ctrl = 13'h0F0; up.data = DW'(8'h30); dn.ready = 0;
    step();
    up.data = DW'(8'h31);
    step();
    Rst = 1; up.valid = 0;
    step();
    Rst = 0;
    n_cmp++; if (dn.valid !== 1'b0 || dn.ctrl !== '0 || dn.data !== '0 || up.ready !== 1'b1) begin n_err++; $display("FAIL rstmid got v=%b c=%h d=%h r=%b exp 0 0 0 1", dn.valid, dn.ctrl, dn.data, up.ready); end
    up.valid = 1; up.data = DW'(8'h40); dn.ready = 1;
    step();
    n_cmp++; if (dn.valid !== 1'b1 || dn.data !== DW'(8'h40) || dn.ctrl !== 13'h0F0) begin n_err++; $display("FAIL rstmid_pass got v=%b d=%h c=%h exp v=1 d=40 c=0f0", dn.valid, dn.data, dn.ctrl); end
    up.valid = 0;
    step();
    n_cmp++; if (dn.valid !== 1'b0) begin n_err++; $display("FAIL rstmid_drain got %b exp 0", dn.valid); end
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    Rst = 1; up.valid = 0; dn.ready = 0;
    step();
    Rst = 0;
    n_cmp++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin n_err++; $display("FAIL perf_reset got s=%0d b=%0d exp 0 0", stall_cnt, bubble_cnt); end
    up.valid = 1; up.data = DW'(1); up.ctrl = 13'h001;
    step();
    up.valid = 0;
    step(); step(); step();
    flush = 1; dn.ready = 1;
    step();
    flush = 0;
    step(); step();
    n_cmp++; if (stall_cnt !== NW'(3) || bubble_cnt !== NW'(4)) begin n_err++; $display("FAIL perf_count got s=%0d b=%0d exp 3 4", stall_cnt, bubble_cnt); end
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (bubble_cnt !== '1 || stall_cnt !== NW'(3)) begin n_err++; $display("FAIL perf_bsat got s=%0d b=%0d exp 3 15", stall_cnt, bubble_cnt); end
    up.valid = 1; dn.ready = 0;
    step();
    up.valid = 0;
    for (int i = 0; i < 20; i++) step();
    n_cmp++; if (stall_cnt !== '1) begin n_err++; $display("FAIL perf_ssat got s=%0d exp 15", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
